load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, giving the number of valid 32-bit words in the attached data memory.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit, pipeline access request present.
REQ-005 The block SHALL have port req_ready, output, 1 bit, block can accept a request.
REQ-006 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 The block SHALL have port req_unsigned, input, 1 bit, zero-extend loads when set.
REQ-009 The block SHALL have ports req_addr and req_wdata, inputs, 32 bits each: byte address and store data (LSBs significant).
REQ-010 The block SHALL have port resp_valid, output, 1 bit, one-cycle completion pulse with no backpressure.
REQ-011 The block SHALL have ports resp_rdata (32 bits) and resp_fault (1 bit), outputs: load result and access fault.
REQ-012 The block SHALL have ports mem_we (1 bit), mem_addr (32 bits) and mem_wdata (32 bits), outputs to the word-wide data memory.
REQ-013 The block SHALL have port mem_rdata, input, 32 bits, the data memory's combinational read of mem_addr.

Function
REQ-014 The block SHALL implement states IDLE, ACCESS, WRITE and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready, and all req_* fields are registered at that edge.
REQ-016 A fault SHALL be raised when size = 11, half with addr[0] = 1, word with addr[1:0] != 00, or addr[31:2] >= MEM_WORDS.
REQ-017 A faulting request SHALL go IDLE->RESP with resp_fault = 1 and resp_rdata = 0, and mem_we SHALL never assert for it.
REQ-018 mem_addr SHALL equal the registered address with bits [1:0] forced to 00, in every state.
REQ-019 For a load, ACCESS SHALL capture mem_rdata, extract the byte/half selected by addr[1:0], sign- or zero-extend per req_unsigned, register it into resp_rdata, then go to RESP (accept to resp_valid = 2 cycles).
REQ-020 For a word store, ACCESS SHALL drive mem_we = 1 and mem_wdata = req_wdata, then go to RESP.
REQ-021 For a byte/half store, ACCESS SHALL latch mem_rdata (mem_we = 0); WRITE SHALL drive mem_we = 1 with the latched word, replacing only the addressed lane(s) with req_wdata[7:0] or [15:0]; then go to RESP (read-modify-write, 3 cycles to resp_valid).
REQ-022 mem_we SHALL be a decode of the current state only and asserted in at most one cycle per request; mem_wdata SHALL be 0 whenever mem_we = 0.
REQ-023 RESP SHALL assert resp_valid for exactly one cycle and return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-024 resp_rdata SHALL be 0 for stores and SHALL hold its value between responses.
REQ-025 req_valid SHALL be ignored outside IDLE.

Reset
REQ-026 While rst_n = 0, the block SHALL hold state IDLE, req_ready = 1, resp_valid = 0, resp_fault = 0, resp_rdata = 0, mem_we = 0, mem_addr = 0 and mem_wdata = 0.
REQ-027 Reset asserted in ACCESS or WRITE SHALL drop mem_we immediately, with no partial write committed afterwards and no response for the aborted request.

Structure
REQ-028 The size encodings, the state enumeration and the default MEM_WORDS SHALL live in a shared package used by the pipeline decoder.
REQ-029 Lane extraction and merge SHALL be one combinational sub-module, lsu_lane_align, instanced twice (load extract, store merge).

Verification
REQ-030 Memory word 3 = 0x8899AABB; load byte signed at 0x0D -> resp_rdata = 0xFFFFFFAA, with resp_valid 2 cycles after accept.
REQ-031 Same word; load half unsigned at 0x0E -> resp_rdata = 0x00008899; signed -> 0xFFFF8899.
REQ-032 Word 3 = 0x8899AABB; store byte 0x11 at 0x0F -> exactly one mem_we cycle, in WRITE, with mem_wdata = 0x1199AABB; resp_valid 3 cycles after accept.
REQ-033 Word store of 0x12345678 at 0x3FC -> mem_we in ACCESS, addr 0x3FC; a request at 0x400 (MEM_WORDS = 256) -> resp_fault = 1 and no mem_we.
REQ-034 Half store at 0x01 and word load at 0x02 -> resp_fault = 1 after 1 cycle and memory unchanged.
REQ-035 Reset pulsed during WRITE of a byte store -> mem_we drops in the reset cycle, the target word is unchanged, there is no resp_valid, and req_ready = 1 after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and the pipeline decoder:
// access size encodings, LSU state enumeration, default memory depth.
package load_store_unit_pkg;

    localparam int unsigned LSU_MEM_WORDS = 256;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // Size/alignment check; the range check depends on MEM_WORDS and lives in the LSU.
    function automatic logic is_bad_shape(input size_e size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_bad_shape = 1'b0;
            SIZE_HALF: is_bad_shape = offset[0];
            SIZE_WORD: is_bad_shape = (offset != 2'b00);
            default:   is_bad_shape = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane alignment: extracts a sign/zero-extended byte or half from a word
// (MERGE = 0), or merges store data into the addressed lane(s) (MERGE = 1).
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter bit MERGE = 1'b0
) (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] extracted;
    logic [31:0] merged;

    // Lane select, extension and merge; MERGE picks which result leaves the block.
    always_comb begin
        byte_val  = word[{offset, 3'b000} +: 8];
        half_val  = offset[1] ? word[31:16] : word[15:0];

        case (size)
            SIZE_BYTE: extracted = {{24{~is_unsigned & byte_val[7]}}, byte_val};
            SIZE_HALF: extracted = {{16{~is_unsigned & half_val[15]}}, half_val};
            default:   extracted = word;
        endcase

        merged = word;
        case (size)
            SIZE_BYTE: merged[{offset, 3'b000} +: 8]       = wdata[7:0];
            SIZE_HALF: merged[{offset[1], 4'b0000} +: 16]  = wdata[15:0];
            SIZE_WORD: merged                              = wdata;
            default:   merged                              = word;
        endcase

        result = MERGE ? merged : extracted;
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access to a word-wide data memory.
// Loads take ACCESS; word stores write in ACCESS; sub-word stores do a
// read-modify-write through WRITE. Faulting requests go straight to RESP.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    size_e       size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] rmw_q;
    logic [31:0] load_val;
    logic [31:0] merge_val;
    logic        req_fault;
    logic        word_store;

    assign req_fault = is_bad_shape(size_e'(req_size), req_addr[1:0])
                     || ({2'b00, req_addr[31:2]} >= MEM_WORDS);

    assign word_store = write_q && (size_q == SIZE_WORD);

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    // State decode only, so an asynchronous reset removes the strobe at once.
    assign mem_we     = (state == ST_WRITE) || ((state == ST_ACCESS) && word_store);

    lsu_lane_align #(.MERGE(1'b0)) u_load_extract (
        .word        (mem_rdata),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .result      (load_val)
    );

    lsu_lane_align #(.MERGE(1'b1)) u_store_merge (
        .word        (rmw_q),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .result      (merge_val)
    );

    // Write data is zero whenever no write strobe is presented.
    always_comb begin
        mem_wdata = '0;
        if (state == ST_WRITE)
            mem_wdata = merge_val;
        else if ((state == ST_ACCESS) && word_store)
            mem_wdata = wdata_q;
    end

    // Access sequencer: request capture, load/RMW data handling, response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_BYTE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            rmw_q      <= '0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        size_q     <= size_e'(req_size);
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        if (req_fault) begin
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else begin
                            state      <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!write_q) begin
                        resp_rdata <= load_val;
                        resp_fault <= 1'b0;
                        state      <= ST_RESP;
                    end else if (size_q == SIZE_WORD) begin
                        resp_rdata <= '0;
                        resp_fault <= 1'b0;
                        state      <= ST_RESP;
                    end else begin
                        rmw_q      <= mem_rdata;
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    resp_rdata <= '0;
                    resp_fault <= 1'b0;
                    state      <= ST_RESP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 256-word behavioural memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and watch up to 8 cycles (cycle 1 starts at the accept edge).
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic flt,
                          output int we_cnt, output int we_cyc,
                          output logic [31:0] we_data, output logic [31:0] we_addr);
        @(negedge clk);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rdata = 'x; flt = 1'bx;
        we_cnt = 0; we_cyc = 0; we_data = '0; we_addr = '0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                we_cyc  = c;
                we_data = mem_wdata;
                we_addr = mem_addr;
            end
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                flt   = resp_fault;
            end
        end
    endtask

    int          lat, we_cnt, we_cyc;
    logic [31:0] rdata, we_data, we_addr;
    logic        flt;
    logic        seen_resp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 32'hCAFEF00D;
        mem[3] = 32'h8899AABB;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset values
        rst_n = 1'b0;
        #2;
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_resp_rdata", resp_rdata,      32'd0);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_mem_addr",   mem_addr,        32'd0);
        chk("rst_mem_wdata",  mem_wdata,       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Load byte signed at 0x0D
        do_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("lb_lat",   32'(lat),    32'd2);
        chk("lb_data",  rdata,       32'hFFFFFFAA);
        chk("lb_fault", 32'(flt),    32'd0);
        chk("lb_we",    32'(we_cnt), 32'd0);

        // Load half unsigned / signed at 0x0E
        do_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("lhu_data", rdata, 32'h00008899);
        do_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("lh_data",  rdata, 32'hFFFF8899);
        @(negedge clk);
        chk("rdata_hold", resp_rdata, 32'hFFFF8899);
        chk("valid_pulse", 32'(resp_valid), 32'd0);

        // Store byte 0x11 at 0x0F (read-modify-write)
        do_req(1'b1, 2'b00, 1'b0, 32'h0F, 32'hABCDEF11, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("sb_lat",    32'(lat),    32'd3);
        chk("sb_we_cnt", 32'(we_cnt), 32'd1);
        chk("sb_we_cyc", 32'(we_cyc), 32'd2);
        chk("sb_wdata",  we_data,     32'h1199AABB);
        chk("sb_waddr",  we_addr,     32'h0000000C);
        chk("sb_rdata",  rdata,       32'd0);
        chk("sb_mem",    mem[3],      32'h1199AABB);

        // Word load reads the merged word back
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("lw_data", rdata, 32'h1199AABB);

        // Word store at the last valid word
        do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h12345678, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("sw_lat",    32'(lat),    32'd2);
        chk("sw_we_cnt", 32'(we_cnt), 32'd1);
        chk("sw_we_cyc", 32'(we_cyc), 32'd1);
        chk("sw_waddr",  we_addr,     32'h000003FC);
        chk("sw_wdata",  we_data,     32'h12345678);
        chk("sw_mem",    mem[255],    32'h12345678);

        // Out of range
        do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("oor_fault", 32'(flt),    32'd1);
        chk("oor_lat",   32'(lat),    32'd1);
        chk("oor_we",    32'(we_cnt), 32'd0);
        chk("oor_rdata", rdata,       32'd0);
        chk("oor_mem0",  mem[0],      32'hCAFEF00D);

        // Misaligned half store and word load
        do_req(1'b1, 2'b01, 1'b0, 32'h01, 32'h0000FFFF, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("msh_fault", 32'(flt),    32'd1);
        chk("msh_lat",   32'(lat),    32'd1);
        chk("msh_we",    32'(we_cnt), 32'd0);
        chk("msh_mem",   mem[0],      32'hCAFEF00D);
        do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("msw_fault", 32'(flt), 32'd1);
        chk("msw_lat",   32'(lat), 32'd1);
        chk("msw_rdata", rdata,    32'd0);

        // Illegal size
        do_req(1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("ill_fault", 32'(flt), 32'd1);

        // Half store into upper lane, then unsigned byte load
        do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h7777BEEF, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("sh_fault", 32'(flt), 32'd0);
        chk("sh_lat",   32'(lat), 32'd3);
        chk("sh_mem",   mem[3],   32'hBEEFAABB);
        do_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("lbu_data", rdata, 32'h000000AA);

        // Reset asserted during the WRITE cycle of a byte store
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0C; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_we_in_write", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_drop",    32'(mem_we),    32'd0);
        chk("abort_wdata_zero", mem_wdata,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_mem",   mem[3],         32'hBEEFAABB);
        chk("abort_ready", 32'(req_ready), 32'd1);
        seen_resp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        chk("abort_no_resp", 32'(seen_resp), 32'd0);

        // Unit still works after the aborted access
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, rdata, flt, we_cnt, we_cyc, we_data, we_addr);
        chk("post_lw", rdata, 32'hBEEFAABB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
